// File: rtl/blowfish128_key_loader.sv
// Key loader in front of the Blowfish-128 key-schedule generator: packs a streamed
// user key into key0..key7, starts the generator and reports completion or error.
module blowfish128_key_loader #(
   parameter int MIN_WORDS      = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        Clk,
   input  logic        RstN,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic        in_encrypt,
   output logic [63:0] key0,
   output logic [63:0] key1,
   output logic [63:0] key2,
   output logic [63:0] key3,
   output logic [63:0] key4,
   output logic [63:0] key5,
   output logic [63:0] key6,
   output logic [63:0] key7,
   output logic [3:0]  key_length,
   output logic        Encrypt,
   output logic        Enable,
   input  logic        skey_ready,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LOAD      = 3'd1;
   localparam logic [2:0] DRAIN     = 3'd2;
   localparam logic [2:0] END_CHECK = 3'd3;
   localparam logic [2:0] WAIT_LOW  = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]     MIN_LEN    = 4'(MIN_WORDS);
   localparam logic [3:0]     MAX_LEN    = 4'd14;

   logic [2:0]    state;
   logic [3:0]    cnt;
   logic [3:0]    next_cnt;
   logic [TW-1:0] timer;
   logic [31:0]   words [14];
   logic          accept;
   logic          overflow;
   logic          store;
   logic          launch;

   assign in_ready = (state == IDLE) || (state == LOAD) || (state == DRAIN);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign overflow = (state == LOAD) && (cnt == MAX_LEN);
   assign next_cnt = (state == IDLE) ? 4'd1 : cnt + 4'd1;
   assign store    = accept && ((state == IDLE) || ((state == LOAD) && !overflow));
   // Enable and key_length are registered on the last-word handshake so that both
   // are presented during the single END_CHECK cycle.
   assign launch   = store && in_last && (next_cnt >= MIN_LEN);

   assign key0 = {words[1],  words[0]};
   assign key1 = {words[3],  words[2]};
   assign key2 = {words[5],  words[4]};
   assign key3 = {words[7],  words[6]};
   assign key4 = {words[9],  words[8]};
   assign key5 = {words[11], words[10]};
   assign key6 = {words[13], words[12]};
   assign key7 = '0;

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state      <= IDLE;
         cnt        <= '0;
         timer      <= '0;
         key_length <= '0;
         Encrypt    <= 1'b0;
         Enable     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         for (int i = 0; i < 14; i++) words[i] <= '0;
      end else begin
         Enable <= 1'b0;
         done   <= 1'b0;
         if (launch) begin
            Enable     <= 1'b1;
            key_length <= next_cnt;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < 14; i++) words[i] <= '0;
                  words[0] <= in_data;
                  Encrypt  <= in_encrypt;
                  error    <= 1'b0;
                  cnt      <= 4'd1;
                  state    <= in_last ? END_CHECK : LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (overflow) begin
                     error <= 1'b1;
                     state <= in_last ? IDLE : DRAIN;
                  end else begin
                     words[cnt] <= in_data;
                     cnt        <= next_cnt;
                     if (in_last) state <= END_CHECK;
                  end
               end
            end
            DRAIN: begin
               if (accept && in_last) state <= IDLE;
            end
            END_CHECK: begin
               timer <= '0;
               if (cnt < MIN_LEN) begin
                  error <= 1'b1;
                  state <= IDLE;
               end else begin
                  state <= WAIT_LOW;
               end
            end
            // The generator may still show a stale ready from a previous run, so a
            // low level must be seen before a high level counts as completion.
            WAIT_LOW: begin
               if (timer == TIMER_LAST) begin
                  error <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
                  if (!skey_ready) state <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (skey_ready) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (timer == TIMER_LAST) begin
                  error <= 1'b1;
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blowfish128_key_loader.sv
// Scoreboard bench for blowfish128_key_loader with a small skeygen model attached;
// stimulus pushes expected Enable/done/error events, a monitor pops and compares them.
module tb_blowfish128_key_loader;

   localparam int TIMEOUT_CYCLES = 64;

   logic        Clk;
   logic        RstN;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_encrypt;
   logic [63:0] key0, key1, key2, key3, key4, key5, key6, key7;
   logic [3:0]  key_length;
   logic        Encrypt;
   logic        Enable;
   logic        skey_ready;
   logic        busy;
   logic        done;
   logic        error;

   blowfish128_key_loader #(
      .MIN_WORDS      (1),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .Clk        (Clk),
      .RstN       (RstN),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_encrypt (in_encrypt),
      .key0       (key0),
      .key1       (key1),
      .key2       (key2),
      .key3       (key3),
      .key4       (key4),
      .key5       (key5),
      .key6       (key6),
      .key7       (key7),
      .key_length (key_length),
      .Encrypt    (Encrypt),
      .Enable     (Enable),
      .skey_ready (skey_ready),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // Generator model: keeps the old ready level for two cycles after Enable, drops
   // it, then raises it with P1 = P-init word 1 xor the first key word.
   // Mode 1 holds ready stuck high, mode 2 stuck low.
   int          model_mode = 0;
   int          model_t;
   logic [31:0] model_p1;
   always @(posedge Clk) begin
      if (!RstN) begin
         skey_ready <= 1'b1;
         model_t    <= 0;
         model_p1   <= '0;
      end else if (model_mode == 1) begin
         skey_ready <= 1'b1;
      end else if (model_mode == 2) begin
         skey_ready <= 1'b0;
      end else if (Enable) begin
         model_t  <= 1;
         model_p1 <= 32'h243F6A88 ^ key0[31:0];
      end else if (model_t != 0) begin
         model_t <= model_t + 1;
         if (model_t == 2) skey_ready <= 1'b0;
         if (model_t == 6) begin
            skey_ready <= 1'b1;
            model_t    <= 0;
         end
      end
   end

   localparam int EV_ENABLE = 0;
   localparam int EV_DONE   = 1;
   localparam int EV_ERR_HS = 2;
   localparam int EV_ERR_TO = 3;

   typedef struct {
      int           kind;
      logic [447:0] keys;
      logic [3:0]   len;
      logic         enc;
      logic [31:0]  p1;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   words_planned = 0;
   int   hs_count = 0;
   int   last_hs = -100;
   int   last_en = -100;
   logic error_q = 1'b0;

   task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_event(input int kind, input logic [447:0] keys, input logic [3:0] len,
                             input logic enc, input logic [31:0] p1);
      exp_t e;
      e.kind = kind;
      e.keys = keys;
      e.len  = len;
      e.enc  = enc;
      e.p1   = p1;
      q.push_back(e);
   endtask

   task automatic handle_event(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         check_output("unexpected event", 512'(kind), 512'(99));
         return;
      end
      e = q.pop_front();
      check_output("event kind", 512'(kind), 512'(e.kind));
      if (kind != e.kind) return;
      case (kind)
         EV_ENABLE: begin
            check_output("enable key bus", 512'({key6, key5, key4, key3, key2, key1, key0}), 512'(e.keys));
            check_output("enable key7", 512'(key7), 512'(0));
            check_output("enable key_length", 512'(key_length), 512'(e.len));
            check_output("enable Encrypt", 512'(Encrypt), 512'(e.enc));
            check_output("enable latency", 512'(cyc), 512'(last_hs + 1));
            check_output("enable in_ready", 512'(in_ready), 512'(0));
            last_en = cyc;
         end
         EV_DONE: begin
            check_output("done P1", 512'(model_p1), 512'(e.p1));
            check_output("done without error", 512'(error), 512'(0));
         end
         EV_ERR_HS: begin
            check_output("overflow error timing", 512'(cyc), 512'(last_hs + 1));
            check_output("error without done", 512'(done), 512'(0));
         end
         default: begin
            check_output("timeout error timing", 512'(cyc), 512'(last_en + TIMEOUT_CYCLES + 1));
            check_output("error without done", 512'(done), 512'(0));
         end
      endcase
   endtask

   always @(negedge Clk) begin
      if (RstN) begin
         if (Enable) handle_event(EV_ENABLE);
         if (done) handle_event(EV_DONE);
         if (error && !error_q) handle_event(q.size() != 0 ? q[0].kind : EV_ERR_HS);
         if (in_valid && in_ready) begin
            hs_count++;
            last_hs = cyc;
         end
      end
      error_q = error;
   end

   // Offers one word, holding it until in_ready is seen mid-cycle; called just after a rising edge.
   task automatic apply_stimulus(input logic [31:0] data, input logic last, input logic enc, input int gap);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge Clk);
         #1;
      end
      in_valid   = 1'b1;
      in_data    = data;
      in_last    = last;
      in_encrypt = enc;
      for (int w = 0; w < 300 && !ok; w++) begin
         @(negedge Clk);
         ok = in_ready;
         @(posedge Clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) check_output("handshake wait", 512'(0), 512'(1));
   endtask

   task automatic send_key(input logic [31:0] base, input logic [31:0] step, input int n,
                           input logic enc, input int gap, input logic last_on_final);
      for (int k = 0; k < n; k++) begin
         apply_stimulus(base + step * 32'(k), last_on_final && (k == n - 1), (k == 0) ? enc : ~enc, gap);
         words_planned++;
      end
   endtask

   function automatic logic [447:0] packed_key(input logic [31:0] base, input logic [31:0] step, input int n);
      logic [447:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[k*32 +: 32] = base + step * 32'(k);
      return r;
   endfunction

   task automatic wait_drain();
      for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge Clk);
      repeat (2) @(posedge Clk);
      #1;
      check_output("scoreboard drained", 512'(q.size()), 512'(0));
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      RstN       = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      in_encrypt = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      RstN = 1'b1;

      $display("[TB] reset state");
      check_output("reset key bus", {key7, key6, key5, key4, key3, key2, key1, key0}, '0);
      check_output("reset key_length", 512'(key_length), 512'(0));
      check_output("reset flags", 512'({Encrypt, Enable, done, error, busy}), 512'(0));
      check_output("reset in_ready", 512'(in_ready), 512'(1));

      $display("[TB] four-word key");
      push_event(EV_ENABLE, {320'h0, 64'h0C0D0E0F08090A0B, 64'h0405060700010203}, 4'd4, 1'b1, '0);
      push_event(EV_DONE, '0, '0, 1'b0, 32'h243E688B);
      send_key(32'h00010203, 32'h04040404, 4, 1'b1, 0, 1'b1);
      wait_drain();
      check_output("idle after done", 512'(busy), 512'(0));
      check_output("key0 held", 512'(key0), 512'(64'h0405060700010203));

      $display("[TB] fifteen-word overflow");
      push_event(EV_ERR_HS, '0, '0, 1'b0, '0);
      send_key(32'h10000000, 32'h00000001, 15, 1'b1, 0, 1'b0);
      check_output("draining busy", 512'(busy), 512'(1));
      send_key(32'h20000000, 32'h00000001, 1, 1'b0, 0, 1'b1);
      wait_drain();
      check_output("overflow error sticky", 512'(error), 512'(1));
      check_output("overflow idle", 512'({busy, in_ready}), 512'(2'b01));
      check_output("overflow key_length kept", 512'(key_length), 512'(4));
      check_output("overflow 14 words packed", 512'({key6, key5, key4, key3, key2, key1, key0}),
                   512'(packed_key(32'h10000000, 32'h00000001, 14)));

      $display("[TB] single-word key");
      push_event(EV_ENABLE, {384'h0, 64'h00000000DEADBEEF}, 4'd1, 1'b0, '0);
      push_event(EV_DONE, '0, '0, 1'b0, 32'hFA92D467);
      send_key(32'hDEADBEEF, 32'h0, 1, 1'b0, 0, 1'b1);
      wait_drain();
      check_output("error cleared by word 0", 512'(error), 512'(0));

      $display("[TB] skey_ready stuck high");
      model_mode = 1;
      push_event(EV_ENABLE, packed_key(32'hA0A0A0A0, 32'h01010101, 2), 4'd2, 1'b1, '0);
      push_event(EV_ERR_TO, '0, '0, 1'b0, '0);
      send_key(32'hA0A0A0A0, 32'h01010101, 2, 1'b1, 0, 1'b1);
      wait_drain();
      check_output("timeout high idle", 512'({busy, error}), 512'(2'b01));

      $display("[TB] skey_ready stuck low");
      model_mode = 2;
      push_event(EV_ENABLE, packed_key(32'hB0B0B0B0, 32'h01010101, 2), 4'd2, 1'b0, '0);
      push_event(EV_ERR_TO, '0, '0, 1'b0, '0);
      send_key(32'hB0B0B0B0, 32'h01010101, 2, 1'b0, 0, 1'b1);
      wait_drain();
      check_output("timeout low idle", 512'({busy, error}), 512'(2'b01));
      model_mode = 0;

      $display("[TB] reset during load");
      send_key(32'hC0000000, 32'h11111111, 3, 1'b1, 0, 1'b0);
      RstN = 1'b0;
      @(posedge Clk);
      #1;
      RstN = 1'b1;
      check_output("mid-load reset key bus", {key7, key6, key5, key4, key3, key2, key1, key0}, '0);
      check_output("mid-load reset outputs", 512'({key_length, Encrypt, Enable, done, error, busy}), 512'(0));
      push_event(EV_ENABLE, packed_key(32'hD0000001, 32'h00000100, 2), 4'd2, 1'b0, '0);
      push_event(EV_DONE, '0, '0, 1'b0, 32'h243F6A88 ^ 32'hD0000001);
      send_key(32'hD0000001, 32'h00000100, 2, 1'b0, 0, 1'b1);
      wait_drain();

      $display("[TB] gaps and back-pressure");
      push_event(EV_ENABLE, packed_key(32'hE0000000, 32'h00010001, 5), 4'd5, 1'b1, '0);
      push_event(EV_DONE, '0, '0, 1'b0, 32'h243F6A88 ^ 32'hE0000000);
      push_event(EV_ENABLE, packed_key(32'hF1000000, 32'h00000007, 3), 4'd3, 1'b0, '0);
      push_event(EV_DONE, '0, '0, 1'b0, 32'h243F6A88 ^ 32'hF1000000);
      send_key(32'hE0000000, 32'h00010001, 5, 1'b1, 2, 1'b1);
      send_key(32'hF1000000, 32'h00000007, 3, 1'b0, 0, 1'b1);
      wait_drain();
      check_output("words accepted", 512'(hs_count), 512'(words_planned));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/blowfish128_key_loader.md
Name: blowfish128_key_loader

Overview:
- Upstream stage of the Blowfish-128 P-array key-schedule generator (skeygen).
- Collects a variable-length user key as a stream of 32-bit words over a valid/ready handshake and packs it into the key0..key7 bus.
- Sets key_length (32-bit word count) and Encrypt, pulses Enable, then waits for skey_ready and reports completion or error.
- Holds the key bus stable while the generator runs.

Parameters:
- MIN_WORDS, 1: minimum legal key length in 32-bit words (1..14).
- TIMEOUT_CYCLES, 64: maximum cycles in the WAIT_* states before error (>=4).

Ports:
- Clk  in  1  clock; all logic on rising edge.
- RstN  in  1  reset, synchronous, active-low.
- in_valid  in  1  key word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  32  key word; first word accepted is word 0.
- in_last  in  1  marks final key word; qualified by in_valid & in_ready.
- in_encrypt  in  1  direction; sampled with word 0.
- key0..key7  out  64 each  packed key to skeygen.
- key_length  out  4  number of valid 32-bit words, 1..14.
- Encrypt  out  1  registered direction to skeygen.
- Enable  out  1  one-cycle start pulse to skeygen.
- skey_ready  in  1  P-array-ready flag from skeygen.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when skeygen reports ready.
- error  out  1  sticky; cleared on the next accepted word 0 or by reset.

Behaviour:
- Reset (RstN=0 at a clock edge):
  - state=IDLE; all key registers, key_length, Encrypt, Enable, done, error and the word counter = 0.
  - Reset is honoured in every state, including mid-load and mid-wait.
- Word packing:
  - Word k (0..13) goes to key[k>>1] bits [(k&1)*32 +: 32], so word 0 = key0[31:0] and word 1 = key0[63:32].
  - key7 is always 0; the generator uses only 448 bits.
  - Unwritten words read 0. All key registers clear to 0 when word 0 is accepted.
- IDLE:
  - in_ready=1.
  - On handshake: clear keys, store word 0, latch in_encrypt into Encrypt, clear error, cnt=1.
  - Next state is LOAD, or END_CHECK if in_last is set.
- LOAD:
  - in_ready=1. Each handshake stores word cnt and does cnt+=1.
  - On in_last, go to END_CHECK.
  - If a handshake arrives with cnt==14 (a 15th word), do not store it; set error and go to DRAIN.
- DRAIN:
  - in_ready=1; words are discarded.
  - On the in_last handshake go to IDLE. Keys and key_length are left as they were.
- END_CHECK (1 cycle, in_ready=0):
  - If cnt<MIN_WORDS: set error, go to IDLE.
  - Otherwise: key_length=cnt, Enable=1 for exactly this one cycle, go to WAIT_LOW.
- WAIT_LOW:
  - Waits for skey_ready==0. skeygen keeps a stale 1 for up to 2 cycles after Enable.
- WAIT_HIGH:
  - On skey_ready==1: done=1 for 1 cycle, go to IDLE.
- Timeout:
  - A counter runs across WAIT_LOW and WAIT_HIGH.
  - When it reaches TIMEOUT_CYCLES: error=1, go to IDLE, no done pulse.
- Handshake and stability rules:
  - in_ready=0 in END_CHECK, WAIT_LOW and WAIT_HIGH.
  - key*, key_length and Encrypt do not change from END_CHECK until the next word 0 is accepted.
  - done and error are never asserted in the same cycle.
  - Enable is never asserted in any state other than END_CHECK.
- Latency: the Enable pulse comes 1 cycle after the last-word handshake.

Test Plan:
- Send 4 words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F (last on the 4th), in_encrypt=1 -> key0=0x0405060700010203, key1=0x0C0D0E0F08090A0B, key2..key7=0, key_length=4, Encrypt=1, one Enable pulse the cycle after the last handshake; with the skeygen model attached, done pulses once and P1 = 0x243F6A88^0x00010203.
- Send 14 words, then a 15th without in_last, then a 16th with last -> error=1 after the 15th word; no Enable; return to IDLE after the 16th; busy=0.
- Send a single word 0xDEADBEEF with in_last, in_encrypt=0 -> key_length=1, key0=0x00000000DEADBEEF, Encrypt=0, Enable pulse, done pulses.
- Hold skey_ready=1 permanently (stale) -> no done; error asserts after TIMEOUT_CYCLES=64 cycles. With skey_ready stuck at 0 -> same timeout error.
- Drop RstN low for one edge while in LOAD after 3 words -> all outputs 0, state IDLE. The next 2-word load gives key_length=2 with no residue from the earlier words.
- Toggle in_valid with gaps and in_ready back-pressure during the wait states -> no word is lost or duplicated; words offered during WAIT_* are not accepted.
